pc_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch for the multi-cycle MIPS core.
- Computes the next PC for sequential execution, branch (sign-extended offset scaled by 4), jump, jump-register and exception redirects.
- Runs a fetch handshake with instruction memory and presents one instruction window per fetch to the decode/execute datapath.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/next_pc_calc.sv | 61 ++++++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default vectors for the fetch sequencer.
// Imported by the next-PC calculator and the sequencer top.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    EXEC
  } state_t;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_EXC
  } sel_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jump,
// jump-register and exception targets, resolved by fixed priority.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0] i_pc,
  input  logic        i_exc,
  input  logic        i_jr_en,
  input  logic        i_jump_en,
  input  logic        i_branch_en,
  input  logic [31:0] i_branch_off,
  input  logic [25:0] i_jump_target,
  input  logic [31:0] i_jr_addr,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_pc_plus4,
  output sel_t        o_sel
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_jr_target;

  assign w_pc_plus4  = i_pc + 32'd4;
  // Word offset scaled to bytes; wraps modulo 2^32.
  assign w_br_target = w_pc_plus4 + (i_branch_off << 2);
  assign w_j_target  = {w_pc_plus4[31:28], i_jump_target, 2'b00};
  assign w_jr_target = i_jr_addr & 32'hFFFF_FFFC;

  assign o_pc_plus4 = w_pc_plus4;

  always_comb begin
    o_sel     = SEL_SEQ;
    o_next_pc = w_pc_plus4;
    priority case (1'b1)
      i_exc: begin
        o_sel     = SEL_EXC;
        o_next_pc = EXC_VECTOR;
      end
      i_jr_en: begin
        o_sel     = SEL_JR;
        o_next_pc = w_jr_target;
      end
      i_jump_en: begin
        o_sel     = SEL_J;
        o_next_pc = w_j_target;
      end
      i_branch_en: begin
        o_sel     = SEL_BR;
        o_next_pc = w_br_target;
      end
      default: begin
        o_sel     = SEL_SEQ;
        o_next_pc = w_pc_plus4;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch/exec sequencer for the
// multi-cycle core: BOOT -> FETCH <-> EXEC.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [31:0] branch_off,
  input  logic        jump_en,
  input  logic [25:0] jump_target,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_imem_req;
  logic        r_instr_valid;

  logic [31:0] w_next_pc;
  logic [31:0] w_pc_plus4;
  sel_t        w_sel;

  next_pc_calc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc (
    .i_pc          (r_pc),
    .i_exc         (exc),
    .i_jr_en       (jr_en),
    .i_jump_en     (jump_en),
    .i_branch_en   (branch_en),
    .i_branch_off  (branch_off),
    .i_jump_target (jump_target),
    .i_jr_addr     (jr_addr),
    .o_next_pc     (w_next_pc),
    .o_pc_plus4    (w_pc_plus4),
    .o_sel         (w_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_VECTOR;
      r_epc         <= 32'h0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          // Exception wins over a completing fetch.
          if (exc) begin
            r_epc <= r_pc;
            r_pc  <= EXC_VECTOR;
          end else if (imem_ready) begin
            r_state       <= EXEC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall || exc) begin
            if (w_sel == SEL_EXC) begin
              r_epc <= r_pc;
            end
            r_pc          <= w_next_pc;
            r_state       <= FETCH;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= BOOT;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign epc         = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic
// checked every cycle against an arithmetic reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        instr_valid;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_off;
  logic        jump_en;
  logic [25:0] jump_target;
  logic        jr_en;
  logic [31:0] jr_addr;
  logic        exc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .instr_valid (instr_valid),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_off  (branch_off),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .jr_en       (jr_en),
    .jr_addr     (jr_addr),
    .exc         (exc),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .epc         (epc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model phase: 0 boot, 1 fetching, 2 executing.
  int          m_ph;
  logic [31:0] m_pc;
  logic [31:0] m_epc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    imem_ready  = 1'b0;
    stall       = 1'b0;
    branch_en   = 1'b0;
    branch_off  = 32'h0;
    jump_en     = 1'b0;
    jump_target = 26'h0;
    jr_en       = 1'b0;
    jr_addr     = 32'h0;
    exc         = 1'b0;
  endtask

  task automatic model_reset();
    m_ph  = 0;
    m_pc  = 32'h0;
    m_epc = 32'h0;
  endtask

  function automatic logic [31:0] ref_next();
    logic [31:0] q;
    q = m_pc + 32'd4;
    if (jr_en) return jr_addr - (jr_addr % 32'd4);
    if (jump_en)
      return (q / 32'h1000_0000) * 32'h1000_0000
             + {6'b0, jump_target} * 32'd4;
    if (branch_en) return q + branch_off * 32'd4;
    return q;
  endfunction

  task automatic model_step();
    logic [31:0] np;
    np = ref_next();
    case (m_ph)
      0: m_ph = 1;
      1: begin
        if (exc) begin
          m_epc = m_pc;
          m_pc  = 32'h80;
        end else if (imem_ready) begin
          m_ph = 2;
        end
      end
      default: begin
        if (exc) begin
          m_epc = m_pc;
          m_pc  = 32'h80;
          m_ph  = 1;
        end else if (!stall) begin
          m_pc = np;
          m_ph = 1;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("epc", epc, m_epc);
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_ph == 1});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_ph == 2});
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic go_exec();
    clr();
    imem_ready = 1'b1;
    for (int k = 0; k < 4 && m_ph != 2; k++) cyc();
    clr();
  endtask

  task automatic set_pc(input logic [31:0] v);
    go_exec();
    jr_en   = 1'b1;
    jr_addr = v;
    cyc();
    clr();
  endtask

  initial begin
    clr();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    imem_ready = 1'b1;
    cyc();
    chk("boot_addr0", imem_addr, 32'h0);
    repeat (2) cyc();
    chk("boot_addr4", imem_addr, 32'h4);
    repeat (2) cyc();
    chk("boot_addr8", imem_addr, 32'h8);
    cyc();

    set_pc(32'h100);
    go_exec();
    branch_en  = 1'b1;
    branch_off = 32'hFFFF_FFFE;
    cyc();
    chk("br_neg", imem_addr, 32'h0000_00FC);

    set_pc(32'h100);
    go_exec();
    branch_en  = 1'b1;
    branch_off = 32'h0000_0003;
    cyc();
    chk("br_pos", imem_addr, 32'h0000_0110);

    set_pc(32'h4000_0010);
    go_exec();
    jump_en     = 1'b1;
    jump_target = 26'h0000_040;
    cyc();
    chk("jump", imem_addr, 32'h4000_0100);

    set_pc(32'h4000_0010);
    go_exec();
    jump_en     = 1'b1;
    jump_target = 26'h0000_040;
    jr_en       = 1'b1;
    jr_addr     = 32'h1234_5677;
    cyc();
    chk("jr_wins", imem_addr, 32'h1234_5674);

    set_pc(32'h300);
    go_exec();
    stall      = 1'b1;
    branch_en  = 1'b1;
    branch_off = 32'h3;
    repeat (3) begin
      cyc();
      chk("stall_pc", pc, 32'h300);
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
    end
    stall = 1'b0;
    cyc();
    chk("stall_release", imem_addr, 32'h310);
    go_exec();
    cyc();
    chk("branch_once", imem_addr, 32'h314);

    set_pc(32'h200);
    exc = 1'b1;
    cyc();
    chk("exc_fetch_epc", epc, 32'h200);
    chk("exc_fetch_addr", imem_addr, 32'h80);
    clr();

    set_pc(32'h240);
    go_exec();
    stall = 1'b1;
    exc   = 1'b1;
    cyc();
    chk("exc_stall_epc", epc, 32'h240);
    chk("exc_stall_addr", imem_addr, 32'h80);
    clr();

    set_pc(32'hFFFF_FFFC);
    go_exec();
    cyc();
    chk("wrap", imem_addr, 32'h0);

    set_pc(32'h500);
    rst_n = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      imem_ready  = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      exc         = ($urandom_range(0, 15) == 0);
      jr_en       = ($urandom_range(0, 7) == 0);
      jump_en     = ($urandom_range(0, 5) == 0);
      branch_en   = ($urandom_range(0, 2) == 0);
      branch_off  = $urandom;
      jump_target = 26'($urandom);
      jr_addr     = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
